// File: rtl/cl_gf_seq.sv
// cl_gf_seq
//   Sequencer and request front-end for the shared carry-less / polynomial
//   reduction datapath. It accepts one operation at a time and drives the
//   external combinational datapath for one pass (CLMUL, MUL, REDUCE) or two
//   passes (GFMUL: multiply, then reduce). It returns the result over a
//   valid/ready response channel.
//
// Ports
//   clk, rst_l            clock; synchronous active-low reset
//   cfg_we/poly/grade     reduction polynomial configuration write
//   req_*                 request channel (op: 00 CLMUL, 01 MUL, 10 GFMUL, 11 REDUCE)
//   resp_*                response channel (err = invalid grade for GFMUL/REDUCE)
//   dp_*                  controls/operands to datapath, results from datapath
module cl_gf_seq #(
  parameter int DATA_WIDTH = 32,
  localparam int GW = $clog2(DATA_WIDTH) + 1
) (
  input  logic                    clk,
  input  logic                    rst_l,
  input  logic                    cfg_we,
  input  logic [DATA_WIDTH:0]     cfg_poly,
  input  logic [GW-1:0]           cfg_grade,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [1:0]              req_op,
  input  logic [DATA_WIDTH-1:0]   req_a,
  input  logic [DATA_WIDTH-1:0]   req_b,
  output logic                    resp_valid,
  input  logic                    resp_ready,
  output logic [2*DATA_WIDTH-1:0] resp_data,
  output logic                    resp_err,
  output logic                    dp_red_funct,
  output logic                    dp_carry_option,
  output logic [GW-1:0]           dp_polyn_grade,
  output logic [DATA_WIDTH:0]     dp_polyn_red_in,
  output logic [2*DATA_WIDTH-1:0] dp_reduc_in,
  output logic [DATA_WIDTH-1:0]   dp_a,
  output logic [DATA_WIDTH-1:0]   dp_b,
  input  logic [2*DATA_WIDTH-1:0] dp_mult_out,
  input  logic [DATA_WIDTH-1:0]   dp_out_poly
);

  localparam logic [1:0] OP_CLMUL  = 2'b00;
  localparam logic [1:0] OP_MUL    = 2'b01;
  localparam logic [1:0] OP_GFMUL  = 2'b10;
  localparam logic [1:0] OP_REDUCE = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_RED,
    S_RESP
  } state_t;

  state_t                r_state;
  logic [1:0]            r_op;
  logic [DATA_WIDTH:0]   r_poly;
  logic [GW-1:0]         r_grade;

  logic                  w_grade_ok;
  logic                  w_needs_grade;

  always_comb begin
    w_grade_ok    = (r_grade >= GW'(2)) && (r_grade <= GW'(DATA_WIDTH));
    w_needs_grade = (req_op == OP_GFMUL) || (req_op == OP_REDUCE);
    req_ready     = (r_state == S_IDLE);
  end

  // The dp_* registers double as the request snapshot: operands and the
  // polynomial config are latched into them at accept, so a cfg write in the
  // same cycle cannot reach the in-flight op. The product is forwarded
  // straight into resp_data / dp_reduc_in on the MUL-state edge.
  always_ff @(posedge clk) begin
    if (!rst_l) begin
      r_state         <= S_IDLE;
      r_op            <= OP_CLMUL;
      r_poly          <= '0;
      r_grade         <= '0;
      resp_valid      <= 1'b0;
      resp_data       <= '0;
      resp_err        <= 1'b0;
      dp_red_funct    <= 1'b0;
      dp_carry_option <= 1'b0;
      dp_polyn_grade  <= '0;
      dp_polyn_red_in <= '0;
      dp_reduc_in     <= '0;
      dp_a            <= '0;
      dp_b            <= '0;
    end else begin
      if (cfg_we) begin
        r_poly  <= cfg_poly;
        r_grade <= cfg_grade;
      end

      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_op <= req_op;
            if (w_needs_grade && !w_grade_ok) begin
              resp_data  <= '0;
              resp_err   <= 1'b1;
              resp_valid <= 1'b1;
              r_state    <= S_RESP;
            end else begin
              dp_a            <= req_a;
              dp_b            <= req_b;
              dp_polyn_grade  <= r_grade;
              dp_polyn_red_in <= r_poly;
              dp_carry_option <= (req_op == OP_MUL);
              if (req_op == OP_REDUCE) begin
                dp_red_funct <= 1'b1;
                dp_reduc_in  <= {req_b, req_a};
                r_state      <= S_RED;
              end else begin
                dp_red_funct <= 1'b0;
                r_state      <= S_MUL;
              end
            end
          end
        end

        S_MUL: begin
          if (r_op == OP_GFMUL) begin
            dp_red_funct <= 1'b1;
            dp_reduc_in  <= dp_mult_out;
            r_state      <= S_RED;
          end else begin
            resp_data  <= dp_mult_out;
            resp_err   <= 1'b0;
            resp_valid <= 1'b1;
            r_state    <= S_RESP;
          end
        end

        S_RED: begin
          resp_data  <= {{DATA_WIDTH{1'b0}}, dp_out_poly};
          resp_err   <= 1'b0;
          resp_valid <= 1'b1;
          r_state    <= S_RESP;
        end

        S_RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            r_state    <= S_IDLE;
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cl_gf_seq.sv
// Testbench for cl_gf_seq: models the attached datapath behaviourally,
// drives directed and randomized operations and compares responses against
// an op-level reference model of the expected result, error and latency.
module tb_cl_gf_seq;

  logic        clk;
  logic        rst_l;
  logic        cfg_we;
  logic [32:0] cfg_poly;
  logic [5:0]  cfg_grade;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic        resp_valid;
  logic        resp_ready;
  logic [63:0] resp_data;
  logic        resp_err;
  logic        dp_red_funct;
  logic        dp_carry_option;
  logic [5:0]  dp_polyn_grade;
  logic [32:0] dp_polyn_red_in;
  logic [63:0] dp_reduc_in;
  logic [31:0] dp_a;
  logic [31:0] dp_b;
  logic [63:0] dp_mult_out;
  logic [31:0] dp_out_poly;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  logic [32:0] m_poly;
  logic [5:0]  m_grade;

  cl_gf_seq #(.DATA_WIDTH(32)) dut (
    .clk             (clk),
    .rst_l           (rst_l),
    .cfg_we          (cfg_we),
    .cfg_poly        (cfg_poly),
    .cfg_grade       (cfg_grade),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_op          (req_op),
    .req_a           (req_a),
    .req_b           (req_b),
    .resp_valid      (resp_valid),
    .resp_ready      (resp_ready),
    .resp_data       (resp_data),
    .resp_err        (resp_err),
    .dp_red_funct    (dp_red_funct),
    .dp_carry_option (dp_carry_option),
    .dp_polyn_grade  (dp_polyn_grade),
    .dp_polyn_red_in (dp_polyn_red_in),
    .dp_reduc_in     (dp_reduc_in),
    .dp_a            (dp_a),
    .dp_b            (dp_b),
    .dp_mult_out     (dp_mult_out),
    .dp_out_poly     (dp_out_poly)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  function automatic logic [63:0] f_clmul(input logic [31:0] a, input logic [31:0] b);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < 32; i++)
      if (b[i]) r = r ^ ({32'b0, a} << i);
    return r;
  endfunction

  function automatic logic [31:0] f_reduce(input logic [63:0] v, input logic [32:0] p, input int g);
    logic [63:0] r;
    r = v;
    if (g < 1 || g > 32) return v[31:0];
    for (int i = 63; i >= g; i--)
      if (r[i]) r = r ^ ({31'b0, p} << (i - g));
    return r[31:0];
  endfunction

  // Behavioural datapath attached to the controller.
  always_comb begin
    dp_mult_out = dp_carry_option ? ({32'b0, dp_a} * {32'b0, dp_b}) : f_clmul(dp_a, dp_b);
    dp_out_poly = f_reduce(dp_reduc_in, dp_polyn_red_in, int'(dp_polyn_grade));
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cfg_write(input logic [32:0] p, input logic [5:0] g);
    @(negedge clk);
    cfg_we = 1'b1; cfg_poly = p; cfg_grade = g;
    @(posedge clk);
    @(negedge clk);
    cfg_we = 1'b0;
    m_poly = p; m_grade = g;
  endtask

  task automatic gen_cfg(output logic [32:0] p, output logic [5:0] g);
    int unsigned gi;
    logic [32:0] mask;
    if ($urandom_range(0, 7) == 0)
      gi = ($urandom_range(0, 1) == 0) ? $urandom_range(0, 1) : $urandom_range(33, 63);
    else
      gi = $urandom_range(2, 32);
    g = 6'(gi);
    if (gi > 32) mask = '1;
    else mask = (33'(1) << gi) - 33'(1);
    p = (gi <= 32) ? ((33'(1) << gi) | (33'($urandom) & mask) | 33'(1)) : 33'($urandom);
  endtask

  // One full transaction: accept, latency, result, optional backpressure with
  // noise on req_valid/cfg, then response handshake.
  task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input int unsigned hold,
                        input bit cfg_acc, input bit noise,
                        input logic [32:0] np, input logic [5:0] ng,
                        input bit use_const, input logic [63:0] cexp);
    logic [32:0] s_poly;
    logic [5:0]  s_grade;
    bit          ok, e_err;
    logic [63:0] e_data;
    int unsigned e_lat, lat;
    logic [63:0] held_data;
    logic        held_err;

    s_poly  = m_poly;
    s_grade = m_grade;
    ok      = (s_grade >= 6'd2) && (s_grade <= 6'd32);
    e_err   = (op == 2'b10 || op == 2'b11) && !ok;
    case (op)
      2'b00: e_data = f_clmul(a, b);
      2'b01: e_data = {32'b0, a} * {32'b0, b};
      2'b10: e_data = {32'b0, f_reduce(f_clmul(a, b), s_poly, int'(s_grade))};
      default: e_data = {32'b0, f_reduce({b, a}, s_poly, int'(s_grade))};
    endcase
    e_lat = (op == 2'b10) ? 3 : 2;
    if (e_err) begin
      e_data = '0;
      e_lat  = 1;
    end
    if (use_const) e_data = cexp;

    @(negedge clk);
    check({tag, "_req_ready_idle"}, 64'(req_ready), 64'(1));
    req_valid = 1'b1; req_op = op; req_a = a; req_b = b;
    if (cfg_acc) begin
      cfg_we = 1'b1; cfg_poly = np; cfg_grade = ng;
    end
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0; cfg_we = 1'b0;
    req_a = $urandom; req_b = $urandom;
    if (cfg_acc) begin
      m_poly = np; m_grade = ng;
    end

    if (!e_err) begin
      check({tag, "_busy_ready"}, 64'(req_ready), 64'(0));
      check({tag, "_dp_grade"}, 64'(dp_polyn_grade), 64'(s_grade));
      check({tag, "_dp_poly"}, 64'(dp_polyn_red_in), 64'(s_poly));
      if (op == 2'b11) begin
        check({tag, "_red_funct"}, 64'(dp_red_funct), 64'(1));
        check({tag, "_reduc_in"}, dp_reduc_in, {b, a});
      end else begin
        check({tag, "_mul_funct"}, 64'(dp_red_funct), 64'(0));
        check({tag, "_carry"}, 64'(dp_carry_option), 64'(op == 2'b01));
        check({tag, "_dp_ab"}, {dp_a, dp_b}, {a, b});
      end
    end

    lat = 1;
    while (!resp_valid && lat < 8) begin
      @(posedge clk);
      @(negedge clk);
      lat++;
      if (op == 2'b10 && lat == 2)
        check({tag, "_gf_red_funct"}, 64'(dp_red_funct), 64'(1));
    end
    check({tag, "_latency"}, 64'(lat), 64'(e_lat));
    if (!resp_valid) return;
    check({tag, "_data"}, resp_data, e_data);
    check({tag, "_err"}, 64'(resp_err), 64'(e_err));
    held_data = resp_data;
    held_err  = resp_err;

    for (int unsigned i = 0; i < hold; i++) begin
      if (noise) begin
        req_valid = 1'($urandom_range(0, 1));
        req_op    = 2'($urandom_range(0, 3));
        if (i == 1) begin
          cfg_we = 1'b1; cfg_poly = np; cfg_grade = ng;
        end
      end
      @(posedge clk);
      @(negedge clk);
      if (cfg_we) begin
        m_poly = np; m_grade = ng;
      end
      cfg_we = 1'b0;
      check({tag, "_hold_valid"}, 64'(resp_valid), 64'(1));
      check({tag, "_hold_data"}, resp_data, held_data);
      check({tag, "_hold_err"}, 64'(resp_err), 64'(held_err));
      check({tag, "_hold_ready"}, 64'(req_ready), 64'(0));
    end
    req_valid  = 1'b0;
    resp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    resp_ready = 1'b0;
    check({tag, "_post_valid"}, 64'(resp_valid), 64'(0));
    check({tag, "_post_ready"}, 64'(req_ready), 64'(1));
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_req_ready"}, 64'(req_ready), 64'(1));
    check({tag, "_resp_valid"}, 64'(resp_valid), 64'(0));
    check({tag, "_resp_data_err"}, resp_data | 64'(resp_err), 64'(0));
    check({tag, "_dp_ctl"}, 64'({dp_red_funct, dp_carry_option, dp_polyn_grade}), 64'(0));
    check({tag, "_dp_poly"}, 64'(dp_polyn_red_in), 64'(0));
    check({tag, "_dp_reduc"}, dp_reduc_in, 64'(0));
    check({tag, "_dp_ab"}, {dp_a, dp_b}, 64'(0));
  endtask

  initial begin
    logic [32:0] p;
    logic [5:0]  g;
    logic [31:0] a, b;

    rst_l = 1'b0; cfg_we = 1'b0; cfg_poly = '0; cfg_grade = '0;
    req_valid = 1'b0; req_op = '0; req_a = '0; req_b = '0; resp_ready = 1'b0;
    m_poly = '0; m_grade = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_vals("reset");
    rst_l = 1'b1;

    // Grade 0 after reset: GFMUL errors, CLMUL does not.
    run_op("gf_grade0", 2'b10, 32'h57, 32'h83, 0, 0, 0, '0, '0, 1, 64'h0);
    run_op("clmul_3x3", 2'b00, 32'h3, 32'h3, 0, 0, 0, '0, '0, 1, 64'h5);
    run_op("mul_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 0, '0, '0, 1, 64'hFFFF_FFFE_0000_0001);

    cfg_write(33'h11B, 6'd8);
    run_op("gf_aes", 2'b10, 32'h57, 32'h83, 0, 0, 0, '0, '0, 1, 64'hC1);
    run_op("reduce_aes", 2'b11, 32'h2B79, 32'h0, 0, 0, 0, '0, '0, 1, 64'hC1);

    // Backpressure with req_valid/cfg noise, then config-on-accept snapshot.
    run_op("hold", 2'b10, 32'h57, 32'h83, 5, 0, 1, 33'h11D, 6'd8, 1, 64'hC1);
    run_op("gf_11d_cfgacc", 2'b10, 32'h57, 32'h83, 0, 1, 0, 33'h11B, 6'd8, 0, '0);
    run_op("gf_11b_again", 2'b10, 32'h57, 32'h83, 0, 0, 0, '0, '0, 1, 64'hC1);
    run_op("reduce_top", 2'b11, 32'hFFFF_FFFF, 32'h8000_0000, 1, 0, 0, '0, '0, 0, '0);

    // Reset while a GFMUL is in its reduction pass.
    @(negedge clk);
    req_valid = 1'b1; req_op = 2'b10; req_a = 32'h1234; req_b = 32'h5678;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("rst_mid_red_funct", 64'(dp_red_funct), 64'(1));
    rst_l = 1'b0;
    m_poly = '0; m_grade = '0;
    @(posedge clk);
    @(negedge clk);
    check_reset_vals("rst_mid");
    rst_l = 1'b1;
    resp_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      @(negedge clk);
      check("rst_no_resp", 64'(resp_valid), 64'(0));
    end
    resp_ready = 1'b0;
    run_op("gf_after_rst", 2'b10, 32'h57, 32'h83, 0, 0, 0, '0, '0, 1, 64'h0);

    // Randomized operations against the reference model.
    for (int i = 0; i < 80; i++) begin
      logic [32:0] np;
      logic [5:0]  ng;
      if ($urandom_range(0, 3) == 0) begin
        gen_cfg(p, g);
        cfg_write(p, g);
      end
      gen_cfg(np, ng);
      a = $urandom;
      b = $urandom;
      if ($urandom_range(0, 7) == 0) a = '1;
      if ($urandom_range(0, 7) == 0) b = '0;
      run_op("rand", 2'($urandom_range(0, 3)), a, b, $urandom_range(0, 3),
             ($urandom_range(0, 5) == 0), 1'($urandom_range(0, 1)), np, ng, 0, '0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
